// File: rtl/tick_stretcher_pkg.sv
// Shared definitions for the tick stretcher: FSM encoding, system clock rate
// and helpers used to size pulse timing parameters.
package tick_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam int unsigned CLK_FREQ = 32'd100_000_000;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_FREQ / 32'd1000) * ms;
  endfunction

  // Width of a down-counter that must hold max(on_t, off_t) - 1; never below 1 bit.
  function automatic int unsigned tmr_width(input int unsigned on_t, input int unsigned off_t);
    int unsigned m;
    m = (on_t > off_t) ? on_t : off_t;
    return (m > 32'd1) ? $clog2(m) : 32'd1;
  endfunction

endpackage

// File: rtl/tick_stretcher_phase_timer.sv
// Loadable down-counter that stops at zero; zero flags the last cycle of a phase.
module phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/tick_stretcher.sv
// Stretches single-cycle ticks into ON/OFF pulses of fixed width, queueing
// ticks that arrive while a pulse is running in a saturating pending counter.
module tick_stretcher
  import tick_stretcher_pkg::*;
#(
  parameter int unsigned ON_TIME  = ms_to_cycles(32'd100),
  parameter int unsigned OFF_TIME = ms_to_cycles(32'd100),
  parameter int unsigned PEND_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_in,
  input  logic              clear,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned       TMR_W     = tmr_width(ON_TIME, OFF_TIME);
  localparam logic [TMR_W-1:0]  TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]  ON_LOAD   = TMR_W'(ON_TIME - 32'd1);
  localparam logic [TMR_W-1:0]  OFF_LOAD  = TMR_W'(OFF_TIME - 32'd1);
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  state_e              state_q, state_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic                tmr_zero_s;
  logic                tmr_load_s;
  logic [TMR_W-1:0]    tmr_val_s;
  logic                go_s;
  logic                start_s;
  logic                inc_s;
  logic                dec_s;

  phase_timer #(
    .W (TMR_W)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = TMR_ZERO;
    start_s    = 1'b0;
    go_s       = tick_in | (pend_q != PEND_ZERO);
    inc_s      = 1'b0;
    dec_s      = 1'b0;

    if (clear) begin
      // Flush wins over everything, including a same-cycle tick.
      state_d    = IDLE;
      pend_d     = PEND_ZERO;
      ovf_d      = 1'b0;
      tmr_load_s = 1'b1;
      tmr_val_s  = TMR_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (go_s) begin
            state_d    = ON;
            start_s    = 1'b1;
            tmr_load_s = 1'b1;
            tmr_val_s  = ON_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        ON: begin
          if (tmr_zero_s) begin
            state_d    = OFF;
            tmr_load_s = 1'b1;
            tmr_val_s  = OFF_LOAD;
          end else begin
            state_d = ON;
          end
        end
        OFF: begin
          if (tmr_zero_s && go_s) begin
            state_d    = ON;
            start_s    = 1'b1;
            tmr_load_s = 1'b1;
            tmr_val_s  = ON_LOAD;
          end else if (tmr_zero_s) begin
            state_d = IDLE;
          end else begin
            state_d = OFF;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // A start drains the queue first; a tick is only consumed when the queue is empty.
      dec_s = start_s & (pend_q != PEND_ZERO);
      inc_s = tick_in & ~(start_s & (pend_q == PEND_ZERO));

      if (inc_s && !dec_s) begin
        if (pend_q == PEND_MAX) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q + PEND_ONE;
        end
      end else if (dec_s && !inc_s) begin
        pend_d = pend_q - PEND_ONE;
      end else begin
        pend_d = pend_q;
      end
    end

    led_d  = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pend_q  <= PEND_ZERO;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_tick_stretcher.sv
// Directed bench for tick_stretcher with ON_TIME=4, OFF_TIME=3, PEND_W=2.
module tb_tick_stretcher;

  logic       clk;
  logic       reset;
  logic       tick_in;
  logic       clear;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int n_cmp;
  int n_err;

  logic       led_tr  [64];
  logic       busy_tr [64];
  logic [1:0] pend_tr [64];
  logic       ovf_tr  [64];

  tick_stretcher #(
    .ON_TIME  (4),
    .OFF_TIME (3),
    .PEND_W   (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_in  (tick_in),
    .clear    (clear),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset   = 1'b0;
    tick_in = 1'b0;
    clear   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Cycle c is the interval whose negedge samples outputs then drives inputs for c.
  task automatic run_pattern(input logic [63:0] ticks, input logic [63:0] clears, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      led_tr[c]  = led_out;
      busy_tr[c] = busy;
      pend_tr[c] = pending;
      ovf_tr[c]  = overflow;
      tick_in    = ticks[c];
      clear      = clears[c];
    end
    tick_in = 1'b0;
    clear   = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    tick_in = 1'b0;
    clear   = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({led_out, busy, pending, overflow} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_state got=%b exp=%b", {led_out, busy, pending, overflow}, 5'b00000);
    end
  endtask

  task automatic test_single_tick();
    logic [63:0] tk;
    logic [4:0]  exp_v;
    tk = 64'd0;
    tk[10] = 1'b1;
    do_reset();
    run_pattern(tk, 64'd0, 25);
    for (int c = 0; c < 25; c++) begin
      exp_v = {(c >= 11 && c <= 14), (c >= 11 && c <= 17), 2'd0, 1'b0};
      n_cmp++;
      if ({led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]} !== exp_v) begin
        n_err++;
        $display("FAIL single_tick cyc=%0d got=%b exp=%b", c, {led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]}, exp_v);
      end
    end
  endtask

  task automatic test_queue_three();
    logic [63:0] tk;
    logic [4:0]  exp_v;
    logic [1:0]  ep;
    logic        el;
    tk = 64'd0;
    tk[10] = 1'b1;
    tk[11] = 1'b1;
    tk[12] = 1'b1;
    do_reset();
    run_pattern(tk, 64'd0, 35);
    for (int c = 0; c < 35; c++) begin
      ep = (c < 12) ? 2'd0 : (c == 12) ? 2'd1 : (c < 18) ? 2'd2 : (c < 25) ? 2'd1 : 2'd0;
      el = (c >= 11 && c <= 14) || (c >= 18 && c <= 21) || (c >= 25 && c <= 28);
      exp_v = {el, (c >= 11 && c <= 31), ep, 1'b0};
      n_cmp++;
      if ({led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]} !== exp_v) begin
        n_err++;
        $display("FAIL queue_three cyc=%0d got=%b exp=%b", c, {led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]}, exp_v);
      end
    end
  endtask

  task automatic test_saturate();
    logic [63:0] tk;
    logic [4:0]  exp_v;
    logic [1:0]  ep;
    logic        el;
    int          rises;
    tk = 64'd0;
    for (int i = 10; i <= 15; i++) tk[i] = 1'b1;
    do_reset();
    run_pattern(tk, 64'd0, 45);
    rises = 0;
    for (int c = 0; c < 45; c++) begin
      ep = (c < 12) ? 2'd0 : (c == 12) ? 2'd1 : (c == 13) ? 2'd2 : (c < 18) ? 2'd3 :
           (c < 25) ? 2'd2 : (c < 32) ? 2'd1 : 2'd0;
      el = (c >= 11) && (c <= 38) && (((c - 11) % 7) < 4);
      exp_v = {el, (c >= 11 && c <= 38), ep, (c >= 15)};
      n_cmp++;
      if ({led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]} !== exp_v) begin
        n_err++;
        $display("FAIL saturate cyc=%0d got=%b exp=%b", c, {led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]}, exp_v);
      end
      if (c > 0 && led_tr[c] === 1'b1 && led_tr[c-1] === 1'b0) rises++;
    end
    n_cmp++;
    if (rises !== 4) begin
      n_err++;
      $display("FAIL saturate_pulses got=%0d exp=%0d", rises, 4);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] tk;
    logic [4:0]  exp_v;
    logic        el;
    tk = 64'd0;
    tk[10] = 1'b1;
    tk[17] = 1'b1;
    do_reset();
    run_pattern(tk, 64'd0, 30);
    for (int c = 0; c < 30; c++) begin
      el = (c >= 11 && c <= 14) || (c >= 18 && c <= 21);
      exp_v = {el, (c >= 11 && c <= 24), 2'd0, 1'b0};
      n_cmp++;
      if ({led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]} !== exp_v) begin
        n_err++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, {led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]}, exp_v);
      end
    end
  endtask

  task automatic test_full_net_zero();
    logic [63:0] tk;
    logic [4:0]  exp_v;
    logic [1:0]  ep;
    logic        el;
    tk = 64'd0;
    for (int i = 10; i <= 13; i++) tk[i] = 1'b1;
    tk[17] = 1'b1;
    do_reset();
    run_pattern(tk, 64'd0, 50);
    for (int c = 0; c < 50; c++) begin
      ep = (c < 12) ? 2'd0 : (c == 12) ? 2'd1 : (c == 13) ? 2'd2 : (c < 25) ? 2'd3 :
           (c < 32) ? 2'd2 : (c < 39) ? 2'd1 : 2'd0;
      el = (c >= 11) && (c <= 45) && (((c - 11) % 7) < 4);
      exp_v = {el, (c >= 11 && c <= 45), ep, 1'b0};
      n_cmp++;
      if ({led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]} !== exp_v) begin
        n_err++;
        $display("FAIL full_net_zero cyc=%0d got=%b exp=%b", c, {led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]}, exp_v);
      end
    end
  endtask

  task automatic test_clear();
    logic [63:0] tk;
    logic [63:0] cl;
    logic [4:0]  exp_v;
    logic [1:0]  ep;
    logic        el;
    tk = 64'd0;
    cl = 64'd0;
    for (int i = 10; i <= 14; i++) tk[i] = 1'b1;
    tk[19] = 1'b1;
    cl[19] = 1'b1;
    do_reset();
    run_pattern(tk, cl, 32);
    for (int c = 0; c < 32; c++) begin
      ep = (c < 12) ? 2'd0 : (c == 12) ? 2'd1 : (c == 13) ? 2'd2 : (c < 18) ? 2'd3 :
           (c < 20) ? 2'd2 : 2'd0;
      el = (c >= 11 && c <= 14) || (c >= 18 && c <= 19);
      exp_v = {el, (c >= 11 && c <= 19), ep, (c >= 15 && c <= 19)};
      n_cmp++;
      if ({led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]} !== exp_v) begin
        n_err++;
        $display("FAIL clear cyc=%0d got=%b exp=%b", c, {led_tr[c], busy_tr[c], pend_tr[c], ovf_tr[c]}, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] tk;
    tk = 64'd0;
    tk[10] = 1'b1;
    do_reset();
    run_pattern(tk, 64'd0, 17);
    n_cmp++;
    if ({led_tr[16], busy_tr[16]} !== 2'b01) begin
      n_err++;
      $display("FAIL async_pre_off got=%b exp=%b", {led_tr[16], busy_tr[16]}, 2'b01);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({led_out, busy, pending, overflow} !== 5'b00000) begin
      n_err++;
      $display("FAIL async_reset got=%b exp=%b", {led_out, busy, pending, overflow}, 5'b00000);
    end
    @(negedge clk);
    reset = 1'b1;
    run_pattern(64'd0, 64'd0, 15);
    for (int c = 0; c < 15; c++) begin
      n_cmp++;
      if ({led_tr[c], busy_tr[c]} !== 2'b00) begin
        n_err++;
        $display("FAIL post_reset_idle cyc=%0d got=%b exp=%b", c, {led_tr[c], busy_tr[c]}, 2'b00);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b0;
    tick_in = 1'b0;
    clear   = 1'b0;
    test_reset();
    test_single_tick();
    test_queue_three();
    test_saturate();
    test_back_to_back();
    test_full_net_zero();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tick_stretcher.md
# tick_stretcher

Output-side counterpart to the switch-input conditioning path: converts single-cycle event ticks from fast logic into human-visible, fixed-width pulses on a board output such as an LED or buzzer. Each accepted tick produces exactly one ON phase of `ON_TIME` cycles followed by a mandatory OFF gap of `OFF_TIME` cycles. Ticks that arrive while a pulse is in progress are counted in a saturating pending counter and replayed in order. An overflow flag records any that are lost.

## Interface
- `ON_TIME`, default 10_000_000, ON-phase length in clk cycles (100 ms at 100 MHz); must be ≥1.
- `OFF_TIME`, default 10_000_000, OFF-gap length in clk cycles; must be ≥1.
- `PEND_W`, default 4, pending-counter width; maximum pending count is 2^PEND_W−1.
- `clk` input 1: single system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset; clears all state immediately when low.
- `tick_in` input 1: event strobe, one cycle wide, synchronous to `clk`.
- `clear` input 1: synchronous flush.
- `led_out` output 1: stretched pulse, registered.
- `busy` output 1: high whenever state ≠ IDLE, registered.
- `pending` output PEND_W: number of queued events not yet started.
- `overflow` output 1: sticky flag, set when a tick is lost.

## Operation
- FSM states:
  - IDLE: `led_out`=0.
  - ON: `led_out`=1.
  - OFF: `led_out`=0.
- A single down-counter `tmr` is sized to $clog2(max(ON_TIME,OFF_TIME)).
  - Loaded with ON_TIME−1 on entry to ON.
  - Loaded with OFF_TIME−1 on entry to OFF.
  - Decrements by 1 each cycle otherwise.
- A "start" occurs when the FSM enters ON.
- Transitions:
  - IDLE → ON when `tick_in`=1 or `pending`≠0.
  - ON → OFF when `tmr`=0.
  - OFF → ON when `tmr`=0 and (`tick_in`=1 or `pending`≠0).
  - OFF → IDLE when `tmr`=0 and neither condition holds.
- Which event a start consumes:
  - If `pending`≠0, the start consumes the oldest pending event and `pending` decrements.
  - Otherwise the start consumes the same-cycle `tick_in`, and `pending` is unchanged.
- A `tick_in` that is not consumed by a start increments `pending`.
- Simultaneous increment and decrement in one cycle gives a net `pending` change of 0.
- Saturation: if a tick would increment `pending` when it is already at max with no same-cycle decrement, `pending` holds and `overflow` is set.
- A tick arriving at max `pending` in the same cycle as a decrement is not lost, and `overflow` is not set.
- `overflow` clears only on `reset` or `clear`.
- `clear`=1 on the next edge sets:
  - state to IDLE,
  - `led_out`=0, `pending`=0, `overflow`=0,
  - `tmr`=0.
- A `tick_in` in the same cycle as `clear` is dropped. `clear` has priority over all other events.
- Reset (`reset`=0, asynchronous) sets all outputs to 0 and state to IDLE, including mid-ON or mid-OFF; no pulse resumes after release.

## Timing
- Start latency from IDLE: tick at edge N gives `led_out` and `busy` high after edge N+1.
- `led_out` is high for exactly ON_TIME cycles, then low for exactly OFF_TIME cycles.
- Back-to-back pulse period is exactly ON_TIME+OFF_TIME cycles; there is no IDLE cycle between queued pulses.
- `busy` falls on the same edge that OFF exits to IDLE.
- `pending` and `overflow` update on the edge after the causing `tick_in`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- The shared project package/header holds:
  - state encodings IDLE=2'd0, ON=2'd1, OFF=2'd2,
  - the CLK_FREQ constant and ms-to-cycles helper used to derive ON_TIME and OFF_TIME.
- One sub-module, `phase_timer`: a loadable down-counter with `load`, `load_val` and `zero` outputs, sized by parameter.
- The FSM and pending counter stay in `tick_stretcher`.

## Test plan
All scenarios use ON_TIME=4, OFF_TIME=3, PEND_W=2 (max pending 3).

1. Single tick at cycle 10 from IDLE → `led_out`=1 cycles 11–14, 0 cycles 15–17; `busy`=1 cycles 11–17, 0 at 18; `pending` stays 0.
2. Ticks at cycles 10, 11, 12 → `pending` reads 1 at 12 and 2 at 13; `led_out` rises at 11, 18 and 25; `pending`=0 after 25; `overflow`=0.
3. Six ticks at cycles 10–15 → `pending` saturates at 3, `overflow`=1 from cycle 15 and stays set; exactly 4 pulses, rising at 11, 18, 25 and 32.
4. Tick in the last OFF cycle with `pending`=0 → `led_out` rises on the next cycle with no IDLE gap; `pending` stays 0.
5. With `pending`=3, a tick in the same cycle as an OFF→ON start → `pending` stays 3, `overflow` stays 0.
6. Reset and clear:
   - `clear` mid-ON with `pending`=2 and `overflow`=1 → next cycle `led_out`=0, `busy`=0, `pending`=0, `overflow`=0.
   - `reset` asserted low mid-OFF, asynchronously between edges → all outputs 0 immediately.
   - After `reset` release with no ticks → `led_out` stays 0.
